// File: rtl/frame_buffer_pingpong_pkg.sv
// Shared parameters, RGB332 field positions and FSM state encoding for the ping-pong frame buffer.
// Optional power-on bank clearing is enabled by defining FB_CLEAR_ON_RESET_EN.
package frame_buffer_pingpong_pkg;

  localparam int unsigned MATRIX_SIZE = 16;
  localparam int unsigned COLOR_DEPTH = 8;
  localparam int unsigned ADDR_WIDTH  = 8;
  localparam int unsigned NUM_PIXELS  = 1 << ADDR_WIDTH;

  // RGB332 packing {R[7:5], G[4:2], B[1:0]}
  localparam int unsigned RED_MSB = 7;
  localparam int unsigned RED_LSB = 5;
  localparam int unsigned GRN_MSB = 4;
  localparam int unsigned GRN_LSB = 2;
  localparam int unsigned BLU_MSB = 1;
  localparam int unsigned BLU_LSB = 0;

  typedef logic [COLOR_DEPTH-1:0] pixel_t;
  typedef logic [ADDR_WIDTH-1:0]  addr_t;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StWrite    = 2'd1,
    StWaitSwap = 2'd2,
    StClear    = 2'd3
  } fb_state_e;

  function automatic logic is_last_addr(addr_t addr);
    return addr == addr_t'(NUM_PIXELS - 1);
  endfunction

endpackage

// File: rtl/frame_buffer_pingpong_if.sv
// Raster pixel stream handshake between the pixel source and the frame buffer.
interface frame_buffer_pingpong_if;
  import frame_buffer_pingpong_pkg::*;

  logic   s_valid;
  logic   s_ready;
  logic   s_sof;
  pixel_t s_data;

  modport master (output s_valid, output s_data, output s_sof, input s_ready);
  modport slave  (input s_valid, input s_data, input s_sof, output s_ready);

endinterface

// File: rtl/frame_buffer_pingpong_bank_ram.sv
// One frame bank: a single write port and a registered read port (read data resets to 0).
module fb_bank_ram
  import frame_buffer_pingpong_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   wr_en,
  input  addr_t  wr_addr,
  input  pixel_t wr_data,
  input  addr_t  rd_addr,
  output pixel_t rd_data
);

  pixel_t mem [NUM_PIXELS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/frame_buffer_pingpong.sv
// Double-buffered LED frame store: writes the pixel stream into the back bank, serves reads from
// the front bank and swaps only on disp_frame_end. FB_CLEAR_ON_RESET_EN zeroes both banks at reset.
module frame_buffer_pingpong
  import frame_buffer_pingpong_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst_n,
  frame_buffer_pingpong_if.slave         pix,
  input  logic                           disp_frame_end,
  input  addr_t                          rd_addr,
  output pixel_t                         rd_data,
  output logic                           front_bank,
  output logic                           frame_pending,
  output logic                           sof_err,
  output logic [7:0]                     drop_cnt
);

`ifdef FB_CLEAR_ON_RESET_EN
  localparam fb_state_e ResetState = StClear;
  localparam logic      ResetZero  = 1'b1;
`else
  localparam fb_state_e ResetState = StIdle;
  localparam logic      ResetZero  = 1'b0;
`endif

  fb_state_e  state_q, state_d;
  addr_t      wr_addr_q, wr_addr_d;
  logic       front_q, front_d;
  logic       pending_q, pending_d;
  logic       sof_err_q, sof_err_d;
  logic [7:0] drop_q, drop_d;
  logic       sel_q;
  logic       rd_zero_q;

  logic   ready, xfer;
  logic   we_back, we_all;
  addr_t  waddr;
  pixel_t wdata;
  pixel_t rd0, rd1;

  assign ready       = (state_q == StIdle) || (state_q == StWrite);
  assign xfer        = pix.s_valid && ready;
  assign pix.s_ready = ready;

  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    front_d   = front_q;
    pending_d = pending_q;
    sof_err_d = sof_err_q;
    drop_d    = drop_q;
    we_back   = 1'b0;
    we_all    = 1'b0;
    waddr     = wr_addr_q;
    wdata     = pix.s_data;
    case (state_q)
      StIdle: begin
        if (xfer) begin
          if (pix.s_sof) begin
            we_back   = 1'b1;
            waddr     = '0;
            wr_addr_d = addr_t'(1);
            state_d   = StWrite;
          end else if (drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
          end
        end
      end
      StWrite: begin
        if (xfer) begin
          we_back = 1'b1;
          if (pix.s_sof) begin
            // Restart the frame from pixel (0,0); the partial frame is overwritten.
            waddr     = '0;
            wr_addr_d = addr_t'(1);
            sof_err_d = 1'b1;
          end else if (is_last_addr(wr_addr_q)) begin
            wr_addr_d = '0;
            pending_d = 1'b1;
            state_d   = StWaitSwap;
          end else begin
            wr_addr_d = wr_addr_q + addr_t'(1);
          end
        end
      end
      StWaitSwap: begin
        if (disp_frame_end) begin
          front_d   = ~front_q;
          pending_d = 1'b0;
          sof_err_d = 1'b0;
          state_d   = StIdle;
        end
      end
`ifdef FB_CLEAR_ON_RESET_EN
      StClear: begin
        we_all    = 1'b1;
        wdata     = '0;
        wr_addr_d = wr_addr_q + addr_t'(1);
        if (is_last_addr(wr_addr_q)) begin
          state_d = StIdle;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ResetState;
      wr_addr_q <= '0;
      front_q   <= 1'b0;
      pending_q <= 1'b0;
      sof_err_q <= 1'b0;
      drop_q    <= '0;
      sel_q     <= 1'b0;
      rd_zero_q <= ResetZero;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      front_q   <= front_d;
      pending_q <= pending_d;
      sof_err_q <= sof_err_d;
      drop_q    <= drop_d;
      sel_q     <= front_q;
      rd_zero_q <= (state_q == StClear);
    end
  end

  // The back bank is always the one not being displayed.
  fb_bank_ram u_bank0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (we_all || (we_back && front_q)),
    .wr_addr (waddr),
    .wr_data (wdata),
    .rd_addr (rd_addr),
    .rd_data (rd0)
  );

  fb_bank_ram u_bank1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (we_all || (we_back && !front_q)),
    .wr_addr (waddr),
    .wr_data (wdata),
    .rd_addr (rd_addr),
    .rd_data (rd1)
  );

  assign rd_data       = rd_zero_q ? '0 : (sel_q ? rd1 : rd0);
  assign front_bank    = front_q;
  assign frame_pending = pending_q;
  assign sof_err       = sof_err_q;
  assign drop_cnt      = drop_q;

endmodule

// File: tb/tb_frame_buffer_pingpong.sv
// Directed bench for frame_buffer_pingpong: swap timing, drop/sof_err flags, read path contents.
module tb_frame_buffer_pingpong;
  import frame_buffer_pingpong_pkg::*;

`ifdef FB_CLEAR_ON_RESET_EN
  localparam logic ClearEn = 1'b1;
`else
  localparam logic ClearEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       disp = 1'b0;
  addr_t      rd_addr = '0;
  pixel_t     rd_data;
  logic       front_bank, frame_pending, sof_err;
  logic [7:0] drop_cnt;

  int checks   = 0;
  int failures = 0;

  frame_buffer_pingpong_if pix ();

  frame_buffer_pingpong dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pix            (pix),
    .disp_frame_end (disp),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .front_bank     (front_bank),
    .frame_pending  (frame_pending),
    .sof_err        (sof_err),
    .drop_cnt       (drop_cnt)
  );

  always #5 clk = ~clk;

  // One transfer; inputs change 1 time unit after the edge, outputs are read there too.
  task automatic push(input pixel_t data, input logic sof);
    pix.s_valid = 1'b1;
    pix.s_data  = data;
    pix.s_sof   = sof;
    @(posedge clk); #1;
    pix.s_valid = 1'b0;
    pix.s_sof   = 1'b0;
  endtask

  task automatic read_at(input addr_t a);
    rd_addr = a;
    @(posedge clk); #1;
  endtask

  task automatic pulse_disp();
    disp = 1'b1;
    @(posedge clk); #1;
    disp = 1'b0;
  endtask

  task automatic do_reset();
    int n;
    pix.s_valid = 1'b0;
    pix.s_sof   = 1'b0;
    pix.s_data  = '0;
    disp        = 1'b0;
    rst_n       = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    n = 0;
    while (pix.s_ready !== 1'b1 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (pix.s_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready_timeout got=%b exp=1", pix.s_ready);
    end
  endtask

  task automatic test_reset();
    pix.s_valid = 1'b0;
    pix.s_sof   = 1'b0;
    pix.s_data  = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (front_bank !== 1'b0) begin failures++; $display("FAIL rst_front got=%b exp=0", front_bank); end
    checks++;
    if (frame_pending !== 1'b0) begin
      failures++; $display("FAIL rst_pending got=%b exp=0", frame_pending);
    end
    checks++;
    if (sof_err !== 1'b0) begin failures++; $display("FAIL rst_sof_err got=%b exp=0", sof_err); end
    checks++;
    if (drop_cnt !== 8'd0) begin failures++; $display("FAIL rst_drop got=%0d exp=0", drop_cnt); end
    checks++;
    if (rd_data !== 8'h00) begin failures++; $display("FAIL rst_rd_data got=%h exp=00", rd_data); end
    checks++;
    if (pix.s_ready !== !ClearEn) begin
      failures++; $display("FAIL rst_ready got=%b exp=%b", pix.s_ready, !ClearEn);
    end
    do_reset();
  endtask

  task automatic test_drop();
    do_reset();
    for (int i = 0; i < 10; i++) push(8'(i), 1'b0);
    checks++;
    if (drop_cnt !== 8'd10) begin failures++; $display("FAIL drop_10 got=%0d exp=10", drop_cnt); end
    checks++;
    if (frame_pending !== 1'b0 || pix.s_ready !== 1'b1) begin
      failures++;
      $display("FAIL drop_idle got=pend%b/rdy%b exp=pend0/rdy1", frame_pending, pix.s_ready);
    end
    for (int i = 0; i < 245; i++) push(8'(i), 1'b0);
    checks++;
    if (drop_cnt !== 8'd255) begin failures++; $display("FAIL drop_255 got=%0d exp=255", drop_cnt); end
    for (int i = 0; i < 45; i++) push(8'(i), 1'b0);
    checks++;
    if (drop_cnt !== 8'd255) begin failures++; $display("FAIL drop_sat got=%0d exp=255", drop_cnt); end
  endtask

  task automatic test_first_frame();
    do_reset();
    for (int i = 0; i < 255; i++) push(8'(i), i == 0);
    checks++;
    if (frame_pending !== 1'b0) begin
      failures++; $display("FAIL f1_pend_early got=%b exp=0", frame_pending);
    end
    push(8'hFF, 1'b0);
    checks++;
    if (frame_pending !== 1'b1) begin failures++; $display("FAIL f1_pend got=%b exp=1", frame_pending); end
    checks++;
    if (pix.s_ready !== 1'b0) begin failures++; $display("FAIL f1_ready got=%b exp=0", pix.s_ready); end
    pulse_disp();
    checks++;
    if (front_bank !== 1'b1) begin failures++; $display("FAIL f1_swap got=%b exp=1", front_bank); end
    checks++;
    if (frame_pending !== 1'b0 || pix.s_ready !== 1'b1) begin
      failures++;
      $display("FAIL f1_post_swap got=pend%b/rdy%b exp=pend0/rdy1", frame_pending, pix.s_ready);
    end
    read_at(8'h3A);
    checks++;
    if (rd_data !== 8'h3A) begin failures++; $display("FAIL f1_rd_3a got=%h exp=3a", rd_data); end
    read_at(8'hFF);
    checks++;
    if (rd_data !== 8'hFF) begin failures++; $display("FAIL f1_rd_ff got=%h exp=ff", rd_data); end
    pulse_disp();
    checks++;
    if (front_bank !== 1'b1) begin failures++; $display("FAIL idle_disp got=%b exp=1", front_bank); end
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    addr_t a;
    for (int i = 0; i < 256; i++) begin
      a = 8'(i * 37 + 11);
      rd_addr = a;
      push(~8'(i), i == 0);
      if (rd_data !== a) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL f2_front_stable got=%0d bad exp=0", bad); end
    read_at(8'h05);
    checks++;
    if (rd_data !== 8'h05) begin failures++; $display("FAIL f2_pre_swap got=%h exp=05", rd_data); end
    pulse_disp();
    checks++;
    if (front_bank !== 1'b0) begin failures++; $display("FAIL f2_swap got=%b exp=0", front_bank); end
    read_at(8'h05);
    checks++;
    if (rd_data !== 8'hFA) begin failures++; $display("FAIL f2_rd_05 got=%h exp=fa", rd_data); end
  endtask

  task automatic test_sof_err();
    for (int i = 0; i < 100; i++) push(8'(i + 8'h40), i == 0);
    checks++;
    if (sof_err !== 1'b0) begin failures++; $display("FAIL se_early got=%b exp=0", sof_err); end
    push(8'h5A, 1'b1);
    checks++;
    if (sof_err !== 1'b1) begin failures++; $display("FAIL se_set got=%b exp=1", sof_err); end
    for (int i = 1; i < 256; i++) push(8'(i) ^ 8'h5A, 1'b0);
    checks++;
    if (sof_err !== 1'b1 || frame_pending !== 1'b1) begin
      failures++; $display("FAIL se_hold got=err%b/pend%b exp=err1/pend1", sof_err, frame_pending);
    end
    pulse_disp();
    checks++;
    if (sof_err !== 1'b0 || front_bank !== 1'b1) begin
      failures++; $display("FAIL se_clear got=err%b/front%b exp=err0/front1", sof_err, front_bank);
    end
    read_at(8'h50);
    checks++;
    if (rd_data !== 8'h0A) begin failures++; $display("FAIL se_rd_50 got=%h exp=0a", rd_data); end
    read_at(8'h10);
    checks++;
    if (rd_data !== 8'h4A) begin failures++; $display("FAIL se_rd_10 got=%h exp=4a", rd_data); end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 255; i++) begin
      disp = (i == 100);
      push(8'(i) ^ 8'hC3, i == 0);
    end
    disp = 1'b0;
    checks++;
    if (front_bank !== 1'b1) begin failures++; $display("FAIL sim_write_disp got=%b exp=1", front_bank); end
    disp = 1'b1;
    push(8'hFF ^ 8'hC3, 1'b0);
    disp = 1'b0;
    checks++;
    if (front_bank !== 1'b1 || frame_pending !== 1'b1) begin
      failures++;
      $display("FAIL sim_last got=front%b/pend%b exp=front1/pend1", front_bank, frame_pending);
    end
    repeat (50) @(posedge clk);
    #1;
    checks++;
    if (front_bank !== 1'b1 || pix.s_ready !== 1'b0) begin
      failures++;
      $display("FAIL sim_wait got=front%b/rdy%b exp=front1/rdy0", front_bank, pix.s_ready);
    end
    pulse_disp();
    checks++;
    if (front_bank !== 1'b0) begin failures++; $display("FAIL sim_swap got=%b exp=0", front_bank); end
    read_at(8'hFF);
    checks++;
    if (rd_data !== 8'h3C) begin failures++; $display("FAIL sim_rd_ff got=%h exp=3c", rd_data); end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 50; i++) push(8'(i), i == 0);
    do_reset();
    push(8'h11, 1'b0);
    checks++;
    if (drop_cnt !== 8'd1 || frame_pending !== 1'b0 || front_bank !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got=drop%0d/pend%b/front%b exp=drop1/pend0/front0",
               drop_cnt, frame_pending, front_bank);
    end
  endtask

`ifdef FB_CLEAR_ON_RESET_EN
  task automatic test_clear();
    int n = 0;
    int bad = 0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rd_addr = 8'h3A;
    while (pix.s_ready !== 1'b1 && n < 400) begin
      @(posedge clk); #1;
      n++;
      if (pix.s_ready !== 1'b1 && rd_data !== 8'h00) bad++;
    end
    checks++;
    if (n != 256) begin failures++; $display("FAIL clr_cycles got=%0d exp=256", n); end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL clr_rd_forced got=%0d bad exp=0", bad); end
    bad = 0;
    for (int i = 0; i < 256; i += 17) begin
      read_at(8'(i));
      if (rd_data !== 8'h00) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL clr_bank0 got=%0d bad exp=0", bad); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef FB_CLEAR_ON_RESET_EN
    test_clear();
`endif
    test_drop();
    test_first_frame();
    test_back_to_back();
    test_sof_err();
    test_simultaneous();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
